// File: rtl/pfpu_jobq.sv
// Job-queue sequencer: buffers CSR-staged mesh descriptors and launches them on the PFPU
// back-to-back, raising a single irq when the queue drains.
module pfpu_jobq #(
   parameter logic [4:0]  csr_addr   = 5'h00,
   parameter int unsigned depth_log2 = 2
) (
   input  logic        sys_clk,
   input  logic        sys_rst,

   input  logic [14:0] csr_a,
   input  logic        csr_we,
   input  logic [31:0] csr_di,
   output logic [31:0] csr_do,

   output logic        irq,

   output logic        start,
   input  logic        busy,
   output logic [28:0] dma_base,
   output logic [6:0]  hmesh_last,
   output logic [6:0]  vmesh_last,
   output logic [1:0]  cp_page
);

   localparam int unsigned depth = 1 << depth_log2;

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StLaunch = 2'd1;
   localparam logic [1:0] StRun    = 2'd2;
   localparam logic [1:0] StDone   = 2'd3;

   typedef logic [depth_log2-1:0] ptr_t;
   typedef logic [depth_log2:0]   cnt_t;

   logic [1:0]  state_q;
   logic [2:0]  wait_q;
   logic [28:0] stage_dma_q;
   logic [6:0]  stage_h_q;
   logic [6:0]  stage_v_q;
   logic [1:0]  stage_page_q;
   ptr_t        wr_ptr_q;
   ptr_t        rd_ptr_q;
   cnt_t        count_q;
   logic        enable_q;
   logic        ovf_q;
   logic        tmo_q;
   logic [15:0] done_cnt_q;

   // Descriptor packing: {dma[28:0], h[6:0], v[6:0], page[1:0]}
   logic [44:0] fifo_mem [depth];
   logic [44:0] head;

   logic        csr_sel;
   logic [2:0]  idx;
   logic        wr_dma, wr_mesh, wr_push, wr_ctrl, wr_done;
   logic        flush, empty, full, pop, push_ok, ovf_set, timeout_hit;
   logic [31:0] status;
   logic [31:0] rd_data;

   assign csr_sel = (csr_a[14:10] == csr_addr);
   assign idx     = csr_a[2:0];
   assign wr_dma  = csr_sel & csr_we & (idx == 3'd0);
   assign wr_mesh = csr_sel & csr_we & (idx == 3'd1);
   assign wr_push = csr_sel & csr_we & (idx == 3'd2);
   assign wr_ctrl = csr_sel & csr_we & (idx == 3'd3);
   assign wr_done = csr_sel & csr_we & (idx == 3'd4);

   assign flush   = wr_ctrl & csr_di[1];
   assign empty   = (count_q == '0);
   // Count never exceeds depth, so its MSB alone marks the full condition.
   assign full    = count_q[depth_log2];
   assign pop     = (state_q == StIdle) & enable_q & ~empty;
   // A pop in the same cycle frees a slot, so a push while full is still accepted.
   assign push_ok = wr_push & (~full | pop) & ~flush;
   assign ovf_set = wr_push & full & ~pop;
   assign timeout_hit = (state_q == StLaunch) & ~busy & (wait_q == 3'd7);
   assign head    = fifo_mem[rd_ptr_q];

   always_comb begin
      status        = 32'd0;
      status[0]     = (state_q != StIdle);
      status[1]     = full;
      status[2]     = empty;
      status[3]     = ovf_q;
      status[4]     = tmo_q;
      status[12:8]  = 5'(count_q);

      rd_data = 32'd0;
      if (csr_sel) begin
         case (idx)
            3'd0:    rd_data = {stage_dma_q, 3'b000};
            3'd1:    rd_data = {14'd0, stage_page_q, 1'b0, stage_v_q, 1'b0, stage_h_q};
            3'd2:    rd_data = status;
            3'd3:    rd_data = {31'd0, enable_q};
            3'd4:    rd_data = {16'd0, done_cnt_q};
            default: rd_data = 32'd0;
         endcase
      end
   end

   always_ff @(posedge sys_clk) begin
      if (push_ok) begin
         fifo_mem[wr_ptr_q] <= {stage_dma_q, stage_h_q, stage_v_q, stage_page_q};
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q      <= StIdle;
         wait_q       <= 3'd0;
         stage_dma_q  <= 29'd0;
         stage_h_q    <= 7'd0;
         stage_v_q    <= 7'd0;
         stage_page_q <= 2'd0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         enable_q     <= 1'b0;
         ovf_q        <= 1'b0;
         tmo_q        <= 1'b0;
         done_cnt_q   <= 16'd0;
         csr_do       <= 32'd0;
         irq          <= 1'b0;
         start        <= 1'b0;
         dma_base     <= 29'd0;
         hmesh_last   <= 7'd0;
         vmesh_last   <= 7'd0;
         cp_page      <= 2'd0;
      end else begin
         csr_do <= rd_data;

         if (wr_dma) begin
            stage_dma_q <= csr_di[31:3];
         end
         if (wr_mesh) begin
            stage_h_q    <= csr_di[6:0];
            stage_v_q    <= csr_di[14:8];
            stage_page_q <= csr_di[17:16];
         end
         if (wr_ctrl) begin
            enable_q <= csr_di[0];
         end

         if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
         end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + ptr_t'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + ptr_t'(1);
            if (push_ok && !pop)      count_q <= count_q + cnt_t'(1);
            else if (!push_ok && pop) count_q <= count_q - cnt_t'(1);
         end

         if (flush)        ovf_q <= 1'b0;
         else if (ovf_set) ovf_q <= 1'b1;
         if (flush)            tmo_q <= 1'b0;
         else if (timeout_hit) tmo_q <= 1'b1;

         if (wr_done)                done_cnt_q <= 16'd0;
         else if (state_q == StDone) done_cnt_q <= done_cnt_q + 16'd1;

         start <= pop;
         irq   <= (state_q == StDone) & empty;

         if (pop) begin
            {dma_base, hmesh_last, vmesh_last, cp_page} <= head;
         end

         case (state_q)
            StIdle: begin
               if (pop) begin
                  state_q <= StLaunch;
                  wait_q  <= 3'd0;
               end
            end
            StLaunch: begin
               if (busy)             state_q <= StRun;
               else if (timeout_hit) state_q <= StDone;
               else                  wait_q  <= wait_q + 3'd1;
            end
            StRun: begin
               if (!busy) state_q <= StDone;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
